fft_out_reorder: RTL and testbench

FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

---
 rtl/fft_out_reorder.sv | 150 +++++++++++++++
 tb/tb_fft_out_reorder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong buffer that converts bit-reversed 512-point FFT output
// (16 lanes x 32 beats) to natural order with one registered cycle of latency.
`default_nettype none

module fft_out_reorder #(
  parameter int WIDTH  = 16,
  parameter int N_BEAT = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic signed [WIDTH-1:0] din_re [0:15],
  input  logic signed [WIDTH-1:0] din_im [0:15],
  input  logic                    din_valid,
  output logic signed [WIDTH-1:0] dout_re [0:15],
  output logic signed [WIDTH-1:0] dout_im [0:15],
  output logic                    dout_valid,
  output logic                    dout_sof,
  output logic                    dout_eof
);

  if (N_BEAT != 32) begin : g_nbeat_check
    $error("fft_out_reorder supports only N_BEAT = 32");
  end

  typedef enum logic {IDLE, READ} state_t;

  logic signed [WIDTH-1:0] mem_re [0:1][0:31][0:15];
  logic signed [WIDTH-1:0] mem_im [0:1][0:31][0:15];

  logic [4:0] wcnt;
  logic       wbank;
  logic [1:0] full, full_n;
  logic       wr_done;

  state_t     state, state_n;
  logic [4:0] rcnt, rcnt_n;
  logic       rbank, rbank_n;
  logic       emit, clr_full, other_full;

  logic signed [WIDTH-1:0] rd_re [0:15];
  logic signed [WIDTH-1:0] rd_im [0:15];

  assign wr_done = din_valid && (wcnt == 5'd31);

  // Sample storage carries no reset; a bank is only read after a complete fill.
  always_ff @(posedge clk) begin
    if (din_valid) begin
      for (int l = 0; l < 16; l++) begin
        mem_re[wbank][wcnt][l] <= din_re[l];
        mem_im[wbank][wcnt][l] <= din_im[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wcnt  <= 5'd0;
      wbank <= 1'b0;
    end else if (din_valid) begin
      wcnt <= wcnt + 5'd1;
      if (wcnt == 5'd31) wbank <= ~wbank;
    end
  end

  // Read and write always target different banks, so set and clear never collide.
  always_comb begin
    full_n = full;
    if (clr_full) full_n[rbank] = 1'b0;
    if (wr_done)  full_n[wbank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) full <= 2'b00;
    else       full <= full_n;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      rcnt  <= 5'd0;
      rbank <= 1'b0;
    end else begin
      state <= state_n;
      rcnt  <= rcnt_n;
      rbank <= rbank_n;
    end
  end

  // A write finishing into the other bank this cycle counts as full, giving gapless frames.
  assign other_full = full[~rbank] | (wr_done && (wbank != rbank));

  always_comb begin
    state_n  = state;
    rcnt_n   = rcnt;
    rbank_n  = rbank;
    emit     = 1'b0;
    clr_full = 1'b0;
    case (state)
      IDLE: begin
        if (full[rbank]) begin
          emit    = 1'b1;
          rcnt_n  = 5'd1;
          state_n = READ;
        end
      end
      READ: begin
        emit = 1'b1;
        if (rcnt == 5'd31) begin
          clr_full = 1'b1;
          rbank_n  = ~rbank;
          rcnt_n   = 5'd0;
          state_n  = other_full ? READ : IDLE;
        end else begin
          rcnt_n = rcnt + 5'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output beat k lane j = stored index bitrev9(16k+j): beat {j0..j3,k0}, lane {k1..k4}.
  for (genvar j = 0; j < 16; j++) begin : g_lane
    localparam logic [3:0] LJ = j;
    assign rd_re[j] = mem_re[rbank][{LJ[0], LJ[1], LJ[2], LJ[3], rcnt[0]}][{rcnt[1], rcnt[2], rcnt[3], rcnt[4]}];
    assign rd_im[j] = mem_im[rbank][{LJ[0], LJ[1], LJ[2], LJ[3], rcnt[0]}][{rcnt[1], rcnt[2], rcnt[3], rcnt[4]}];
  end

  always_ff @(posedge clk) begin
    if (!rstn || !emit) begin
      for (int l = 0; l < 16; l++) begin
        dout_re[l] <= '0;
        dout_im[l] <= '0;
      end
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
    end else begin
      for (int l = 0; l < 16; l++) begin
        dout_re[l] <= rd_re[l];
        dout_im[l] <= rd_im[l];
      end
      dout_valid <= 1'b1;
      dout_sof   <= (rcnt == 5'd0);
      dout_eof   <= (rcnt == 5'd31);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_out_reorder.sv
// Directed self-checking bench for fft_out_reorder.
`default_nettype none

module tb_fft_out_reorder;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic din_valid = 1'b0;
  logic signed [W-1:0] din_re [0:15];
  logic signed [W-1:0] din_im [0:15];
  logic signed [W-1:0] dout_re [0:15];
  logic signed [W-1:0] dout_im [0:15];
  logic dout_valid, dout_sof, dout_eof;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fft_out_reorder #(.WIDTH(W), .N_BEAT(32)) dut (
    .clk(clk), .rstn(rstn),
    .din_re(din_re), .din_im(din_im), .din_valid(din_valid),
    .dout_re(dout_re), .dout_im(dout_im),
    .dout_valid(dout_valid), .dout_sof(dout_sof), .dout_eof(dout_eof)
  );

  // Output capture: every valid beat with the cycle it appeared in.
  logic signed [W-1:0] cap_re [0:255][0:15];
  logic signed [W-1:0] cap_im [0:255][0:15];
  logic cap_sof [0:255];
  logic cap_eof [0:255];
  int   cap_cyc [0:255];
  int   ncap = 0, cyc = 0, nz_err = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (dout_valid) begin
      if (ncap < 256) begin
        for (int l = 0; l < 16; l++) begin
          cap_re[ncap][l] = dout_re[l];
          cap_im[ncap][l] = dout_im[l];
        end
        cap_sof[ncap] = dout_sof;
        cap_eof[ncap] = dout_eof;
        cap_cyc[ncap] = cyc;
      end
      ncap++;
    end else begin
      bit nz;
      nz = dout_sof | dout_eof;
      for (int l = 0; l < 16; l++) if (dout_re[l] != 0 || dout_im[l] != 0) nz = 1;
      if (nz) nz_err++;
    end
  end

  function automatic int bitrev9(input int v);
    int r = 0;
    for (int i = 0; i < 9; i++) if (v[i]) r |= (1 << (8 - i));
    return r;
  endfunction

  function automatic logic signed [W-1:0] exp_re(input int k, input int j, input int base);
    return W'(base + bitrev9(16 * k + j));
  endfunction

  function automatic logic signed [W-1:0] exp_im(input int k, input int j, input int base);
    return W'(-(base + bitrev9(16 * k + j)));
  endfunction

  task automatic drive_beat(input int b, input int base);
    for (int l = 0; l < 16; l++) begin
      din_re[l] = W'(base + 16 * b + l);
      din_im[l] = W'(-(base + 16 * b + l));
    end
    din_valid = 1'b1;
  endtask

  // Sends nf frames (frame f uses base 1000*f); acc = cycle that accepted frame 0 beat 31.
  task automatic send_frames(input int nf, input bit gapped, output int acc);
    acc = 0;
    for (int f = 0; f < nf; f++) begin
      for (int b = 0; b < 32; b++) begin
        @(negedge clk);
        drive_beat(b, 1000 * f);
        if (f == 0 && b == 31) begin
          @(posedge clk);
          #2;
          acc = cyc;
        end
        if (gapped) begin
          @(negedge clk);
          din_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic test_reset;
    for (int l = 0; l < 16; l++) begin
      din_re[l] = '0;
      din_im[l] = '0;
    end
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (dout_valid !== 1'b0 || dout_sof !== 1'b0 || dout_eof !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got valid=%b sof=%b eof=%b, want 0 0 0", dout_valid, dout_sof, dout_eof);
    end
    for (int l = 0; l < 16; l++) begin
      vectors++;
      if (dout_re[l] !== 16'sd0 || dout_im[l] !== 16'sd0) begin
        miscompares++;
        $display("FAIL reset_data lane %0d: got re=%0d im=%0d, want 0 0", l, dout_re[l], dout_im[l]);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single_frame;
    int start, acc;
    int sk[7] = '{0, 0, 0, 0, 1, 1, 31};
    int sj[7] = '{0, 1, 2, 3, 0, 1, 15};
    int sv[7] = '{0, 256, 128, 384, 16, 272, 511};
    start = ncap;
    send_frames(1, 1'b0, acc);
    repeat (60) @(posedge clk);
    #2;
    vectors++;
    if (ncap !== start + 32) begin
      miscompares++;
      $display("FAIL single_count: got %0d beats, want 32", ncap - start);
    end
    for (int s = 0; s < 7; s++) begin
      vectors++;
      if (cap_re[start + sk[s]][sj[s]] !== W'(sv[s])) begin
        miscompares++;
        $display("FAIL single_spot beat %0d lane %0d: got re=%0d, want %0d", sk[s], sj[s], cap_re[start + sk[s]][sj[s]], sv[s]);
      end
    end
    for (int k = 0; k < 32; k++) begin
      int i = start + k;
      vectors++;
      if (cap_cyc[i] !== acc + 1 + k || cap_sof[i] !== (k == 0) || cap_eof[i] !== (k == 31)) begin
        miscompares++;
        $display("FAIL single_timing beat %0d: got cyc=%0d sof=%b eof=%b, want cyc=%0d", k, cap_cyc[i], cap_sof[i], cap_eof[i], acc + 1 + k);
      end
      for (int j = 0; j < 16; j++) begin
        vectors++;
        if (cap_re[i][j] !== exp_re(k, j, 0) || cap_im[i][j] !== exp_im(k, j, 0)) begin
          miscompares++;
          $display("FAIL single_data beat %0d lane %0d: got re=%0d im=%0d, want re=%0d im=%0d", k, j, cap_re[i][j], cap_im[i][j], exp_re(k, j, 0), exp_im(k, j, 0));
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int start, acc;
    start = ncap;
    send_frames(2, 1'b0, acc);
    repeat (60) @(posedge clk);
    #2;
    vectors++;
    if (ncap !== start + 64) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d beats, want 64", ncap - start);
    end
    vectors++;
    if (cap_re[start + 32][0] !== 16'sd1000) begin
      miscompares++;
      $display("FAIL b2b_beat32: got re=%0d, want 1000", cap_re[start + 32][0]);
    end
    for (int k = 0; k < 64; k++) begin
      int i = start + k;
      int kk = k % 32;
      int base = (k < 32) ? 0 : 1000;
      vectors++;
      if (cap_cyc[i] !== acc + 1 + k || cap_sof[i] !== (kk == 0) || cap_eof[i] !== (kk == 31)) begin
        miscompares++;
        $display("FAIL b2b_timing beat %0d: got cyc=%0d sof=%b eof=%b, want cyc=%0d", k, cap_cyc[i], cap_sof[i], cap_eof[i], acc + 1 + k);
      end
      for (int j = 0; j < 16; j++) begin
        vectors++;
        if (cap_re[i][j] !== exp_re(kk, j, base) || cap_im[i][j] !== exp_im(kk, j, base)) begin
          miscompares++;
          $display("FAIL b2b_data beat %0d lane %0d: got re=%0d im=%0d, want re=%0d im=%0d", k, j, cap_re[i][j], cap_im[i][j], exp_re(kk, j, base), exp_im(kk, j, base));
        end
      end
    end
  endtask

  task automatic test_gapped;
    int start, acc;
    start = ncap;
    send_frames(1, 1'b1, acc);
    repeat (60) @(posedge clk);
    #2;
    vectors++;
    if (ncap !== start + 32) begin
      miscompares++;
      $display("FAIL gapped_count: got %0d beats, want 32", ncap - start);
    end
    for (int k = 0; k < 32; k++) begin
      int i = start + k;
      vectors++;
      if (cap_cyc[i] !== acc + 1 + k || cap_sof[i] !== (k == 0) || cap_eof[i] !== (k == 31)) begin
        miscompares++;
        $display("FAIL gapped_timing beat %0d: got cyc=%0d sof=%b eof=%b, want cyc=%0d", k, cap_cyc[i], cap_sof[i], cap_eof[i], acc + 1 + k);
      end
      for (int j = 0; j < 16; j++) begin
        vectors++;
        if (cap_re[i][j] !== exp_re(k, j, 0) || cap_im[i][j] !== exp_im(k, j, 0)) begin
          miscompares++;
          $display("FAIL gapped_data beat %0d lane %0d: got re=%0d im=%0d, want re=%0d im=%0d", k, j, cap_re[i][j], cap_im[i][j], exp_re(k, j, 0), exp_im(k, j, 0));
        end
      end
    end
  endtask

  task automatic test_reset_mid_input;
    int start, acc;
    for (int b = 0; b < 20; b++) begin
      @(negedge clk);
      drive_beat(b, 500);
    end
    @(negedge clk);
    din_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    start = ncap;
    send_frames(1, 1'b0, acc);
    repeat (60) @(posedge clk);
    #2;
    vectors++;
    if (ncap !== start + 32) begin
      miscompares++;
      $display("FAIL rst_in_count: got %0d beats, want 32", ncap - start);
    end
    for (int k = 0; k < 32; k++) begin
      int i = start + k;
      vectors++;
      if (cap_cyc[i] !== acc + 1 + k || cap_sof[i] !== (k == 0) || cap_eof[i] !== (k == 31)) begin
        miscompares++;
        $display("FAIL rst_in_timing beat %0d: got cyc=%0d sof=%b eof=%b, want cyc=%0d", k, cap_cyc[i], cap_sof[i], cap_eof[i], acc + 1 + k);
      end
      for (int j = 0; j < 16; j++) begin
        vectors++;
        if (cap_re[i][j] !== exp_re(k, j, 0) || cap_im[i][j] !== exp_im(k, j, 0)) begin
          miscompares++;
          $display("FAIL rst_in_data beat %0d lane %0d: got re=%0d im=%0d, want re=%0d im=%0d", k, j, cap_re[i][j], cap_im[i][j], exp_re(k, j, 0), exp_im(k, j, 0));
        end
      end
    end
  endtask

  task automatic test_extreme;
    int start;
    start = ncap;
    for (int b = 0; b < 32; b++) begin
      @(negedge clk);
      for (int l = 0; l < 16; l++) begin
        din_re[l] = -16'sd32768;
        din_im[l] = 16'sd32767;
      end
      din_valid = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    vectors++;
    if (ncap !== start + 32) begin
      miscompares++;
      $display("FAIL extreme_count: got %0d beats, want 32", ncap - start);
    end
    for (int k = 0; k < 32; k++) begin
      for (int j = 0; j < 16; j++) begin
        vectors++;
        if (cap_re[start + k][j] !== -16'sd32768 || cap_im[start + k][j] !== 16'sd32767) begin
          miscompares++;
          $display("FAIL extreme_data beat %0d lane %0d: got re=%0d im=%0d, want re=-32768 im=32767", k, j, cap_re[start + k][j], cap_im[start + k][j]);
        end
      end
    end
  endtask

  task automatic test_reset_during_output;
    int start, acc, nz0;
    nz0 = nz_err;
    start = ncap;
    send_frames(1, 1'b0, acc);
    for (int i = 0; i < 60 && ncap < start + 11; i++) begin
      @(posedge clk);
      #2;
    end
    vectors++;
    if (ncap !== start + 11) begin
      miscompares++;
      $display("FAIL rst_out_reach: got %0d beats before reset, want 11", ncap - start);
    end
    rstn = 1'b0;
    @(posedge clk);
    #2;
    vectors++;
    if (dout_valid !== 1'b0 || dout_sof !== 1'b0 || dout_eof !== 1'b0 || dout_re[0] !== 16'sd0 || dout_im[5] !== 16'sd0) begin
      miscompares++;
      $display("FAIL rst_out_next: got valid=%b sof=%b eof=%b re0=%0d im5=%0d, want all 0", dout_valid, dout_sof, dout_eof, dout_re[0], dout_im[5]);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (50) @(posedge clk);
    #2;
    vectors++;
    if (ncap !== start + 11) begin
      miscompares++;
      $display("FAIL rst_out_silent: got %0d beats after reset, want 0", ncap - start - 11);
    end
    vectors++;
    if (nz_err !== nz0) begin
      miscompares++;
      $display("FAIL idle_zero: got %0d nonzero idle cycles, want 0", nz_err - nz0);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_reset_mid_input();
    test_extreme();
    test_reset_during_output();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
